// File: rtl/pipe_dest_tracker.sv
// Destination tracker for the E/M/W stages: drives the stage-tagged RegWrite/RD
// signals for forwarding and generates load-use, memory-wait and branch controls.
`timescale 1ns/1ps
module pipe_dest_tracker #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_d,
    input  logic [4:0]       rd_d,
    input  logic             regwrite_d,
    input  logic             load_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic             branch_taken_e,
    input  logic             mem_ready,
    output logic [4:0]       rd_e,
    output logic [4:0]       rd_m,
    output logic [4:0]       rd_w,
    output logic             regwrite_e,
    output logic             regwrite_m,
    output logic             regwrite_w,
    output logic             load_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             mem_timeout,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                WCNT_W   = $clog2(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] CNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } stage_t;

    // The load flag is never consumed once an instruction reaches writeback.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } wb_stage_t;

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } state_t;

    state_t            state_q;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic              err_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    stage_t    e_q, e_d;
    stage_t    m_q, m_d;
    wb_stage_t w_q, w_d;
    stage_t    dec_stage;

    logic m_load;
    logic timeout_hit;
    logic mem_hold;
    logic load_use;

    // mem_hold freezes F/D/E/M; a timeout completes the load exactly like mem_ready.
    assign m_load      = m_q.valid && m_q.load;
    assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == CNT_LAST) && !mem_ready;
    assign mem_hold    = m_load && !mem_ready && !timeout_hit;
    assign load_use    = valid_d && e_q.valid && e_q.load && (e_q.rd != 5'd0) &&
                         ((use_rs1_d && (rs1_d == e_q.rd)) || (use_rs2_d && (rs2_d == e_q.rd)));

    // Branch wins over load-use: the dependent instruction is squashed anyway.
    assign stall_f     = rst && (mem_hold || (load_use && !branch_taken_e));
    assign stall_d     = stall_f;
    assign flush_d     = rst && !mem_hold && branch_taken_e;
    assign flush_e     = rst && !mem_hold && (branch_taken_e || load_use);
    assign mem_timeout = rst && timeout_hit;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        dec_stage = '0;
        e_d       = e_q;
        m_d       = m_q;
        w_d       = '0;
        if (valid_d) begin
            dec_stage.valid    = 1'b1;
            dec_stage.rd       = rd_d;
            dec_stage.regwrite = regwrite_d;
            dec_stage.load     = load_d;
        end
        if (!mem_hold) begin
            e_d          = (branch_taken_e || load_use) ? '0 : dec_stage;
            m_d          = e_q;
            w_d.valid    = m_q.valid;
            w_d.rd       = m_q.rd;
            w_d.regwrite = m_q.regwrite;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    wait_cnt_q <= '0;
                    if (mem_hold) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_hold) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end else begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= '0;
                    end
                    if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign rd_e         = e_q.rd;
    assign rd_m         = m_q.rd;
    assign rd_w         = w_q.rd;
    assign regwrite_e   = e_q.valid && e_q.regwrite && (e_q.rd != 5'd0);
    assign regwrite_m   = m_q.valid && m_q.regwrite && (m_q.rd != 5'd0);
    assign regwrite_w   = w_q.valid && w_q.regwrite && (w_q.rd != 5'd0);
    assign load_e       = e_q.valid && e_q.load;
    assign err          = err_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Self-checking bench for pipe_dest_tracker: directed vector table, hand-written
// memory-wait/timeout/reset sequences, and random traffic against a pipeline model.
`timescale 1ns/1ps
module tb_pipe_dest_tracker;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_d;
    logic [4:0]       rd_d;
    logic             regwrite_d;
    logic             load_d;
    logic [4:0]       rs1_d;
    logic [4:0]       rs2_d;
    logic             use_rs1_d;
    logic             use_rs2_d;
    logic             branch_taken_e;
    logic             mem_ready;
    logic [4:0]       rd_e, rd_m, rd_w;
    logic             regwrite_e, regwrite_m, regwrite_w;
    logic             load_e;
    logic             stall_f, stall_d, flush_d, flush_e;
    logic             mem_timeout, err;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    pipe_dest_tracker #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_d       (valid_d),
        .rd_d          (rd_d),
        .regwrite_d    (regwrite_d),
        .load_d        (load_d),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .use_rs1_d     (use_rs1_d),
        .use_rs2_d     (use_rs2_d),
        .branch_taken_e(branch_taken_e),
        .mem_ready     (mem_ready),
        .rd_e          (rd_e),
        .rd_m          (rd_m),
        .rd_w          (rd_w),
        .regwrite_e    (regwrite_e),
        .regwrite_m    (regwrite_m),
        .regwrite_w    (regwrite_w),
        .load_e        (load_e),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .mem_timeout   (mem_timeout),
        .err           (err),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       valid;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       mr;
    } stim_t;

    typedef struct packed {
        logic [4:0] rd_e;
        logic [4:0] rd_m;
        logic [4:0] rd_w;
        logic [2:0] rw;     // {regwrite_e, regwrite_m, regwrite_w}
        logic       ld_e;
        logic       stall;
        logic       fd;
        logic       fe;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       ld;
    } slot_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic stim_t mk_stim(input int rst_n, input int v, input int rd, input int rw,
                                      input int ld, input int rs1, input int rs2, input int u1,
                                      input int u2, input int br);
        stim_t s;
        s.rst_n = 1'(rst_n);
        s.valid = 1'(v);
        s.rd    = 5'(rd);
        s.rw    = 1'(rw);
        s.ld    = 1'(ld);
        s.rs1   = 5'(rs1);
        s.rs2   = 5'(rs2);
        s.u1    = 1'(u1);
        s.u2    = 1'(u2);
        s.br    = 1'(br);
        s.mr    = 1'b1;
        return s;
    endfunction

    function automatic exp_t ex(input int re, input int rm, input int rwb, input int rwv,
                                input int le, input int st, input int fd, input int fe);
        exp_t e;
        e.rd_e  = 5'(re);
        e.rd_m  = 5'(rm);
        e.rd_w  = 5'(rwb);
        e.rw    = 3'(rwv);
        e.ld_e  = 1'(le);
        e.stall = 1'(st);
        e.fd    = 1'(fd);
        e.fe    = 1'(fe);
        return e;
    endfunction

    function automatic vec_t mk_vec(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        return v;
    endfunction

    // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        rst            = s.rst_n;
        valid_d        = s.valid;
        rd_d           = s.rd;
        regwrite_d     = s.rw;
        load_d         = s.ld;
        rs1_d          = s.rs1;
        rs2_d          = s.rs2;
        use_rs1_d      = s.u1;
        use_rs2_d      = s.u2;
        branch_taken_e = s.br;
        mem_ready      = s.mr;
        @(negedge clk);
    endtask

    // Reference model: an in-order E/M/W slot array plus a count of blocked memory cycles.
    slot_t pipe_m [3];
    int    waited;
    bit    mdl_err;
    int    mdl_cnt;

    function automatic bit writes(input slot_t i);
        return i.v && i.rw && (i.rd != 5'd0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe_m[i] = '{default: 0};
        waited  = 0;
        mdl_err = 1'b0;
        mdl_cnt = 0;
    endtask

    task automatic model_step(input stim_t s, input int n);
        slot_t       e, m, nxt;
        bit          blocked, tmo, dep, x_stall, x_fd, x_fe;
        logic [18:0] x_regs, got_regs;
        logic [9:0]  x_ctrl, got_ctrl;
        e       = pipe_m[0];
        m       = pipe_m[1];
        blocked = 1'b0;
        tmo     = 1'b0;
        dep     = 1'b0;
        if (s.rst_n) begin
            blocked = m.v && m.ld && !s.mr && (waited < MEM_TIMEOUT);
            tmo     = m.v && m.ld && !s.mr && (waited >= MEM_TIMEOUT);
            dep     = s.valid && e.v && e.ld && (e.rd != 5'd0) &&
                      ((s.u1 && s.rs1 == e.rd) || (s.u2 && s.rs2 == e.rd));
        end
        x_stall = blocked || (dep && !s.br);
        x_fd    = s.rst_n && !blocked && s.br;
        x_fe    = s.rst_n && !blocked && (s.br || dep);
        x_regs  = {e.rd, m.rd, pipe_m[2].rd, writes(e), writes(m), writes(pipe_m[2]), e.v && e.ld};
        got_regs = {rd_e, rd_m, rd_w, regwrite_e, regwrite_m, regwrite_w, load_e};
        x_ctrl  = {x_stall, x_stall, x_fd, x_fe, tmo, mdl_err, CNT_W'(mdl_cnt)};
        got_ctrl = {stall_f, stall_d, flush_d, flush_e, mem_timeout, err, stall_cycles};
        check($sformatf("rand%0d regs", n), 32'(got_regs), 32'(x_regs));
        check($sformatf("rand%0d ctrl", n), 32'(got_ctrl), 32'(x_ctrl));
        if (!s.rst_n) begin
            model_reset();
        end else begin
            if (x_stall && mdl_cnt < CNT_MAX) mdl_cnt++;
            if (blocked) begin
                pipe_m[2] = '{default: 0};
                waited++;
            end else begin
                nxt = '{default: 0};
                if (s.valid && !x_fe) nxt = '{v: 1'b1, rd: s.rd, rw: s.rw, ld: s.ld};
                pipe_m[2] = m;
                pipe_m[1] = e;
                pipe_m[0] = nxt;
                waited    = 0;
                if (tmo) mdl_err = 1'b1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[$];
        stim_t rst_s, nop, s, r;
        int    stuck_left;

        rst = 1'b0; valid_d = 1'b0; rd_d = '0; regwrite_d = 1'b0; load_d = 1'b0;
        rs1_d = '0; rs2_d = '0; use_rs1_d = 1'b0; use_rs2_d = 1'b0;
        branch_taken_e = 1'b0; mem_ready = 1'b1;

        rst_s = mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop   = mk_stim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // {rst_n, valid, rd, rw, ld, rs1, rs2, u1, u2, br} -> {rd_e, rd_m, rd_w, rw_emw, load_e, stall, flush_d, flush_e}
        tbl.push_back(mk_vec(mk_stim(0, 1, 5, 1, 1, 1, 0, 1, 0, 0), ex(0, 0, 0, 3'b000, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(mk_stim(0, 1, 7, 1, 0, 2, 3, 1, 1, 1), ex(0, 0, 0, 3'b000, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(mk_stim(1, 1, 5, 1, 1, 1, 0, 1, 0, 0), ex(0, 0, 0, 3'b000, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(nop,                                   ex(5, 0, 0, 3'b100, 1, 0, 0, 0)));
        tbl.push_back(mk_vec(nop,                                   ex(0, 5, 0, 3'b010, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(nop,                                   ex(0, 0, 5, 3'b001, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(mk_stim(1, 1, 5, 1, 1, 2, 0, 1, 0, 0), ex(0, 0, 0, 3'b000, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(mk_stim(1, 1, 6, 1, 0, 5, 1, 1, 1, 0), ex(5, 0, 0, 3'b100, 1, 1, 0, 1)));
        tbl.push_back(mk_vec(mk_stim(1, 1, 6, 1, 0, 5, 1, 1, 1, 0), ex(0, 5, 0, 3'b010, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(nop,                                   ex(6, 0, 5, 3'b101, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(mk_stim(1, 1, 9, 1, 1, 0, 0, 0, 0, 0), ex(0, 6, 0, 3'b010, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(mk_stim(1, 1, 3, 1, 0, 4, 9, 1, 1, 1), ex(9, 0, 6, 3'b101, 1, 0, 1, 1)));
        tbl.push_back(mk_vec(nop,                                   ex(0, 9, 0, 3'b010, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(mk_stim(1, 1, 0, 1, 1, 0, 0, 0, 0, 0), ex(0, 0, 9, 3'b001, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(mk_stim(1, 1, 4, 1, 0, 0, 0, 1, 0, 0), ex(0, 0, 0, 3'b000, 1, 0, 0, 0)));
        tbl.push_back(mk_vec(nop,                                   ex(4, 0, 0, 3'b100, 0, 0, 0, 0)));
        tbl.push_back(mk_vec(nop,                                   ex(0, 4, 0, 3'b010, 0, 0, 0, 0)));

        apply(rst_s);
        foreach (tbl[i]) begin
            apply(tbl[i].s);
            check($sformatf("tbl%0d rd_e", i),    32'(rd_e),       32'(tbl[i].e.rd_e));
            check($sformatf("tbl%0d rd_m", i),    32'(rd_m),       32'(tbl[i].e.rd_m));
            check($sformatf("tbl%0d rd_w", i),    32'(rd_w),       32'(tbl[i].e.rd_w));
            check($sformatf("tbl%0d rw", i),      32'({regwrite_e, regwrite_m, regwrite_w}), 32'(tbl[i].e.rw));
            check($sformatf("tbl%0d load_e", i),  32'(load_e),     32'(tbl[i].e.ld_e));
            check($sformatf("tbl%0d stall_f", i), 32'(stall_f),    32'(tbl[i].e.stall));
            check($sformatf("tbl%0d stall_d", i), 32'(stall_d),    32'(tbl[i].e.stall));
            check($sformatf("tbl%0d flush_d", i), 32'(flush_d),    32'(tbl[i].e.fd));
            check($sformatf("tbl%0d flush_e", i), 32'(flush_e),    32'(tbl[i].e.fe));
        end

        // Memory wait: load in M sees mem_ready low for three cycles.
        apply(rst_s);
        apply(mk_stim(1, 1, 5, 1, 1, 1, 0, 1, 0, 0));
        apply(mk_stim(1, 1, 8, 1, 0, 1, 2, 1, 1, 0));
        check("mw rd_e", 32'(rd_e), 32'd5);
        s = nop;
        s.mr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply(s);
            check($sformatf("mw%0d stall_d", k), 32'(stall_d), 32'd1);
            check($sformatf("mw%0d rd_m", k), 32'(rd_m), 32'd5);
            check($sformatf("mw%0d rd_e", k), 32'(rd_e), 32'd8);
            check($sformatf("mw%0d regwrite_w", k), 32'(regwrite_w), 32'd0);
        end
        apply(nop);
        check("mw release stall_d", 32'(stall_d), 32'd0);
        check("mw release mem_timeout", 32'(mem_timeout), 32'd0);
        apply(nop);
        check("mw done rd_w", 32'(rd_w), 32'd5);
        check("mw done regwrite_w", 32'(regwrite_w), 32'd1);
        check("mw done rd_m", 32'(rd_m), 32'd8);
        check("mw done stall_cycles", 32'(stall_cycles), 32'd3);

        // Timeout: mem_ready never rises; force-completion on the 16th WAIT cycle.
        apply(rst_s);
        apply(mk_stim(1, 1, 7, 1, 1, 0, 0, 0, 0, 0));
        apply(nop);
        for (int k = 2; k <= MEM_TIMEOUT + 2; k++) begin
            apply(s);
            check($sformatf("to%0d rd_m", k), 32'(rd_m), 32'd7);
            check($sformatf("to%0d mem_timeout", k), 32'(mem_timeout), 32'(k == MEM_TIMEOUT + 2));
            check($sformatf("to%0d stall_d", k), 32'(stall_d), 32'(k != MEM_TIMEOUT + 2));
            check($sformatf("to%0d err", k), 32'(err), 32'd0);
        end
        apply(s);
        check("to after mem_timeout", 32'(mem_timeout), 32'd0);
        check("to after err", 32'(err), 32'd1);
        check("to after rd_w", 32'(rd_w), 32'd7);
        check("to after regwrite_w", 32'(regwrite_w), 32'd1);
        check("to after stall_d", 32'(stall_d), 32'd0);
        check("to stall_cycles saturated", 32'(stall_cycles), 32'(CNT_MAX));
        apply(nop);
        check("to sticky err", 32'(err), 32'd1);

        // Reset in the middle of a wait abandons it silently.
        apply(rst_s);
        apply(mk_stim(1, 1, 3, 1, 1, 0, 0, 0, 0, 0));
        apply(nop);
        apply(s);
        apply(s);
        check("rw waiting stall_d", 32'(stall_d), 32'd1);
        r = s;
        r.rst_n = 1'b0;
        apply(r);
        check("rw in reset stall_f", 32'(stall_f), 32'd0);
        check("rw in reset stall_d", 32'(stall_d), 32'd0);
        check("rw in reset mem_timeout", 32'(mem_timeout), 32'd0);
        apply(s);
        check("rw after rd_m", 32'(rd_m), 32'd0);
        check("rw after stall_d", 32'(stall_d), 32'd0);
        check("rw after err", 32'(err), 32'd0);
        check("rw after stall_cycles", 32'(stall_cycles), 32'd0);

        // Random traffic against the model.
        model_reset();
        apply(rst_s);
        stuck_left = 0;
        for (int n = 0; n < 2500; n++) begin
            s.rst_n = ($urandom_range(0, 199) != 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.rd    = 5'($urandom_range(0, 7));
            s.rw    = ($urandom_range(0, 3) != 0);
            s.ld    = ($urandom_range(0, 2) == 0);
            s.rs1   = 5'($urandom_range(0, 7));
            s.rs2   = 5'($urandom_range(0, 7));
            s.u1    = ($urandom_range(0, 3) != 0);
            s.u2    = ($urandom_range(0, 1) != 0);
            s.br    = ($urandom_range(0, 7) == 0);
            if (stuck_left > 0) begin
                stuck_left--;
                s.mr = 1'b0;
            end else begin
                if ($urandom_range(0, 99) == 0) stuck_left = $urandom_range(10, 24);
                s.mr = ($urandom_range(0, 3) != 0);
            end
            apply(s);
            model_step(s, n);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
